// File: rtl/aes_sbox_sched.sv
// Time-multiplexed SubBytes engine: a 128-bit state job and a 32-bit SubWord job
// share N_SBOX S-box instances, with the result returned alongside a one-cycle done pulse.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_sbox_sched #(
  parameter int N_SBOX = 4,
  parameter int ARB_RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  localparam logic [3:0] ST_LAST = 4'(16 / N_SBOX - 1);
  localparam logic [3:0] KW_LAST = 4'(4 / N_SBOX - 1);

  typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  st_out_q, st_out_d;
  logic [31:0]   kw_out_q, kw_out_d;
  logic          st_done_q, st_done_d;
  logic          kw_done_q, kw_done_d;
  logic          last_st_q, last_st_d;
  logic          kw_wins;

  logic [3:0]    byte_idx [N_SBOX];
  logic [7:0]    sb_in    [N_SBOX];
  logic [7:0]    sb_out   [N_SBOX];

  // Lanes always read from the work register, so an idle requester never sees activity.
  for (genvar i = 0; i < N_SBOX; i++) begin : g_sbox
    assign byte_idx[i] = 4'(cnt_q * 4'(N_SBOX)) + 4'(i);
    assign sb_in[i]    = work_q[{byte_idx[i], 3'b000} +: 8];
    aes_sbox u_sbox (
      .in_byte  (sb_in[i]),
      .out_byte (sb_out[i])
    );
  end

  assign kw_wins = kw_req && (!st_req || (ARB_RR == 0) || last_st_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    last_st_d = last_st_q;
    st_gnt    = 1'b0;
    kw_gnt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && kw_wins) begin
          kw_gnt    = 1'b1;
          work_d    = {96'b0, kw_in};
          cnt_d     = '0;
          last_st_d = 1'b0;
          state_d   = RUN_KW;
        end else if (rst_n && st_req) begin
          st_gnt    = 1'b1;
          work_d    = st_in;
          cnt_d     = '0;
          last_st_d = 1'b1;
          state_d   = RUN_ST;
        end
      end
      RUN_ST, RUN_KW: begin
        for (int i = 0; i < N_SBOX; i++) begin
          work_d[{byte_idx[i], 3'b000} +: 8] = sb_out[i];
        end
        cnt_d = cnt_q + 4'd1;
        if (state_q == RUN_ST && cnt_q == ST_LAST) begin
          st_out_d  = work_d;
          st_done_d = 1'b1;
          state_d   = IDLE;
        end else if (state_q == RUN_KW && cnt_q == KW_LAST) begin
          kw_out_d  = work_d[31:0];
          kw_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      last_st_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
      last_st_q <= last_st_d;
    end
  end

  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Scoreboard bench for aes_sbox_sched: four builds (N4 fixed-priority, N4 round-robin, N1, N2)
// checked every cycle against a reference S-box and a cycle model of grants, busy and done.

module tb_aes_sbox_sched;

  localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic         clk;
  logic         rst_n   [4];
  logic         st_req  [4];
  logic [127:0] st_in   [4];
  logic         st_gnt  [4];
  logic         st_done [4];
  logic [127:0] st_out  [4];
  logic         kw_req  [4];
  logic [31:0]  kw_in   [4];
  logic         kw_gnt  [4];
  logic         kw_done [4];
  logic [31:0]  kw_out  [4];
  logic         busy    [4];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box: brute-force inverse search and bitwise affine map.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (a[i]) acc = acc ^ (15'(b) << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (15'(9'h11b) << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox(x[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] x);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_sbox(x[8*k +: 8]);
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NS = (g == 2) ? 1 : ((g == 3) ? 2 : 4);
    localparam int RR = (g == 1) ? 1 : 0;

    aes_sbox_sched #(.N_SBOX(NS), .ARB_RR(RR)) dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .st_req  (st_req[g]),
      .st_in   (st_in[g]),
      .st_gnt  (st_gnt[g]),
      .st_done (st_done[g]),
      .st_out  (st_out[g]),
      .kw_req  (kw_req[g]),
      .kw_in   (kw_in[g]),
      .kw_gnt  (kw_gnt[g]),
      .kw_done (kw_done[g]),
      .kw_out  (kw_out[g]),
      .busy    (busy[g])
    );

    logic [127:0] st_q [$];
    logic [31:0]  kw_q [$];
    logic [127:0] st_hold = '0;
    logic [31:0]  kw_hold = '0;
    int           run_left = 0;
    bit           run_kw = 0;
    bit           exp_st_done = 0;
    bit           exp_kw_done = 0;
    bit           last_st = 1;
    bit           eg_st, eg_kw;

    // Cycle model: expected grant, busy and done each cycle; results queued at grant.
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        st_q.delete();
        kw_q.delete();
        st_hold = '0;
        kw_hold = '0;
        run_left = 0;
        exp_st_done = 0;
        exp_kw_done = 0;
        last_st = 1;
        checkOutput($sformatf("i%0d rst busy", g), busy[g], 0);
        checkOutput($sformatf("i%0d rst st_out", g), st_out[g], 0);
        checkOutput($sformatf("i%0d rst kw_out", g), kw_out[g], 0);
        checkOutput($sformatf("i%0d rst done", g), {st_done[g], kw_done[g]}, 0);
        checkOutput($sformatf("i%0d rst gnt", g), {st_gnt[g], kw_gnt[g]}, 0);
      end else begin
        checkOutput($sformatf("i%0d busy", g), busy[g], run_left != 0);
        checkOutput($sformatf("i%0d st_done", g), st_done[g], exp_st_done);
        checkOutput($sformatf("i%0d kw_done", g), kw_done[g], exp_kw_done);
        if (exp_st_done && st_q.size() > 0) st_hold = st_q.pop_front();
        if (exp_kw_done && kw_q.size() > 0) kw_hold = kw_q.pop_front();
        checkOutput($sformatf("i%0d st_out", g), st_out[g], st_hold);
        checkOutput($sformatf("i%0d kw_out", g), kw_out[g], kw_hold);
        eg_kw = (run_left == 0) && kw_req[g] && (!st_req[g] || RR == 0 || last_st);
        eg_st = (run_left == 0) && st_req[g] && !eg_kw;
        checkOutput($sformatf("i%0d st_gnt", g), st_gnt[g], eg_st);
        checkOutput($sformatf("i%0d kw_gnt", g), kw_gnt[g], eg_kw);
        exp_st_done = (run_left == 1) && !run_kw;
        exp_kw_done = (run_left == 1) && run_kw;
        if (run_left > 0) run_left--;
        if (eg_kw) begin
          kw_q.push_back(ref_word(kw_in[g]));
          run_left = 4 / NS;
          run_kw = 1;
          last_st = 0;
        end
        if (eg_st) begin
          st_q.push_back(ref_state(st_in[g]));
          run_left = 16 / NS;
          run_kw = 0;
          last_st = 1;
        end
      end
    end
  end

  // Requesters hold req until granted; each grant reloads fresh data for the next job.
  task automatic applyStimulus(input int idx, input int n_st, input int n_kw,
                               input logic [127:0] sd, input logic [31:0] kd,
                               output logic [15:0] order);
    int left_st = n_st;
    int left_kw = n_kw;
    int ng = 0;
    bit sg, kg;
    order = '0;
    st_in[idx]  = sd;
    kw_in[idx]  = kd;
    st_req[idx] = (left_st > 0);
    kw_req[idx] = (left_kw > 0);
    for (int c = 0; c < 200 && (left_st > 0 || left_kw > 0); c++) begin
      @(negedge clk);
      sg = st_gnt[idx];
      kg = kw_gnt[idx];
      @(posedge clk);
      #1;
      if (kg) begin
        order[ng] = 1'b1;
        ng++;
        left_kw--;
        kw_in[idx] = $urandom;
        if (left_kw == 0) kw_req[idx] = 1'b0;
      end
      if (sg) begin
        ng++;
        left_st--;
        st_in[idx] = {$urandom, $urandom, $urandom, $urandom};
        if (left_st == 0) st_req[idx] = 1'b0;
      end
    end
    checkOutput($sformatf("i%0d pending", idx), 128'(left_st + left_kw), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ord, ord2;
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; st_req[i] = 1'b0; kw_req[i] = 1'b0;
      st_in[i] = '0; kw_in[i] = '0;
    end
    idle(3);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    idle(2);

    applyStimulus(0, 1, 0, VEC_IN, 32'h0, ord);
    idle(8);
    checkOutput("vec st_out", st_out[0], VEC_OUT);

    applyStimulus(0, 0, 1, '0, 32'h00010203, ord);
    idle(4);
    checkOutput("vec kw_out", kw_out[0], 32'h637c777b);
    checkOutput("st_out kept", st_out[0], VEC_OUT);

    applyStimulus(0, 1, 1, {$urandom, $urandom, $urandom, $urandom}, $urandom, ord);
    checkOutput("fixed tie order", ord[1:0], 2'b01);
    idle(8);

    applyStimulus(1, 2, 2, {$urandom, $urandom, $urandom, $urandom}, $urandom, ord);
    checkOutput("rr tie order", ord[3:0], 4'b0101);
    idle(8);

    applyStimulus(0, 3, 0, {$urandom, $urandom, $urandom, $urandom}, 32'h0, ord);
    idle(8);

    fork
      applyStimulus(2, 1, 0, '0, 32'h0, ord);
      applyStimulus(3, 1, 0, '0, 32'h0, ord2);
    join
    idle(20);
    checkOutput("n1 st_out", st_out[2], {16{8'h63}});
    checkOutput("n2 st_out", st_out[3], {16{8'h63}});

    fork
      applyStimulus(0, 1, 0, VEC_IN, 32'h0, ord);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (st_gnt[0]) break;
        end
        idle(2);
        rst_n[0] = 1'b0;
        #1;
        checkOutput("abort busy", busy[0], 0);
        checkOutput("abort st_out", st_out[0], 0);
        idle(2);
        rst_n[0] = 1'b1;
      end
    join
    idle(10);
    checkOutput("abort no result", st_out[0], 0);

    applyStimulus(0, 1, 0, VEC_IN, 32'h0, ord);
    idle(8);
    checkOutput("reissue st_out", st_out[0], VEC_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
